// File: rtl/pulse_code_gen.sv
// pulse_code_gen: BPSK chip-code pulse generator for the transmit sequencer.
// A GEN rising edge latches the code/timing inputs and runs one frame:
// TX (chips on TX_GATE/PHASE_BIT), optional TAIL (pad out to PULSE_LEN),
// then DONE, which holds SIGNAL_GEN_OVER until the sequencer drops GEN.
// Optional build macro PULSE_CODE_GEN_PREGEN_CHECK_EN adds PREGEN_ERR and
// rejects frames started without a PA warm-up request.
module pulse_code_gen #(
    parameter int MAX_CHIPS = 32
) (
    input  logic                 CLOCK_10M,
    input  logic                 RESET_N,
    input  logic                 GEN,
    input  logic                 PRE_GEN,
    input  logic [MAX_CHIPS-1:0] CODE,
    input  logic [15:0]          CODE_LEN,
    input  logic [15:0]          CODE_DURATION,
    input  logic [15:0]          PULSE_LEN,
    input  logic                 RF_OUTPUT_EN,
    output logic                 PA_EN,
    output logic                 TX_GATE,
    output logic                 PHASE_BIT,
    output logic                 SIGNAL_GEN_OVER,
    output logic                 GEN_BUSY
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
   ,output logic                 PREGEN_ERR
`endif
);

    localparam int LW = $clog2(MAX_CHIPS + 1);  // holds 1..MAX_CHIPS
    localparam int IW = $clog2(MAX_CHIPS);      // chip index 0..MAX_CHIPS-1
    localparam int FW = 21;                     // frame counter / L*D width

    typedef enum logic [1:0] {IDLE, TX, TAIL, DONE} state_t;

    state_t               state_q, state_d;
    logic                 gen_q;
    logic                 armed_q;   // GEN has been seen low since reset
    logic [MAX_CHIPS-1:0] code_q, code_d;
    logic [15:0]          dur_q, dur_d;
    logic [15:0]          plen_q, plen_d;
    logic [FW-1:0]        ld_q, ld_d;
    logic                 rf_q, rf_d;
    logic [FW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        chip_q, chip_d;
    logic [15:0]          dcnt_q, dcnt_d;
    logic                 tx_gate_q, tx_gate_d;
    logic                 phase_q, phase_d;
    logic                 over_q, over_d;
    logic                 busy_q, busy_d;
    logic                 pa_en_q;
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
    logic                 err_q, err_d;
`endif

    logic                 start;
    logic [LW-1:0]        len_clamp;
    logic [15:0]          dur_clamp;
    logic [FW-1:0]        ld_clamp;
    logic [FW-1:0]        cnt_inc;

    // Clamp the requested chip count / chip duration and form L*D at full width.
    always_comb begin
        if (CODE_LEN == 16'd0)
            len_clamp = LW'(1);
        else if (CODE_LEN > 16'(MAX_CHIPS))
            len_clamp = LW'(MAX_CHIPS);
        else
            len_clamp = CODE_LEN[LW-1:0];
        dur_clamp = (CODE_DURATION == 16'd0) ? 16'd1 : CODE_DURATION;
        ld_clamp  = FW'(len_clamp) * FW'(dur_clamp);
    end

    assign start   = (state_q == IDLE) && GEN && !gen_q && armed_q;
    assign cnt_inc = cnt_q + FW'(1);

    // Next-state, frame/chip counters and next registered outputs.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dur_d   = dur_q;
        plen_d  = plen_q;
        ld_d    = ld_q;
        rf_d    = rf_q;
        cnt_d   = cnt_q;
        chip_d  = chip_q;
        dcnt_d  = dcnt_q;
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    code_d  = CODE;
                    dur_d   = dur_clamp;
                    plen_d  = PULSE_LEN;
                    ld_d    = ld_clamp;
                    rf_d    = RF_OUTPUT_EN;
                    cnt_d   = '0;
                    chip_d  = '0;
                    dcnt_d  = '0;
                    state_d = TX;
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
                    // No warm-up request: skip the burst, report completion.
                    if (!PRE_GEN) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            TX: begin
                if (!GEN) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == ld_q) begin
                        state_d = (FW'(plen_q) <= ld_q) ? DONE : TAIL;
                    end else if (dcnt_q + 16'd1 == dur_q) begin
                        dcnt_d = '0;
                        chip_d = chip_q + IW'(1);
                    end else begin
                        dcnt_d = dcnt_q + 16'd1;
                    end
                end
            end
            TAIL: begin
                if (!GEN) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FW'(plen_q))
                        state_d = DONE;
                end
            end
            DONE: begin
                if (!GEN)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        tx_gate_d = (state_d == TX) && rf_d;
        phase_d   = (state_d == TX) && code_d[chip_d];
        busy_d    = (state_d != IDLE);
        over_d    = (state_d == DONE);
    end

    // State, latched frame parameters and registered outputs.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            gen_q     <= 1'b0;
            armed_q   <= 1'b0;
            code_q    <= '0;
            dur_q     <= '0;
            plen_q    <= '0;
            ld_q      <= '0;
            rf_q      <= 1'b0;
            cnt_q     <= '0;
            chip_q    <= '0;
            dcnt_q    <= '0;
            tx_gate_q <= 1'b0;
            phase_q   <= 1'b0;
            over_q    <= 1'b0;
            busy_q    <= 1'b0;
            pa_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            gen_q     <= GEN;
            armed_q   <= armed_q | ~GEN;
            code_q    <= code_d;
            dur_q     <= dur_d;
            plen_q    <= plen_d;
            ld_q      <= ld_d;
            rf_q      <= rf_d;
            cnt_q     <= cnt_d;
            chip_q    <= chip_d;
            dcnt_q    <= dcnt_d;
            tx_gate_q <= tx_gate_d;
            phase_q   <= phase_d;
            over_q    <= over_d;
            busy_q    <= busy_d;
            pa_en_q   <= (PRE_GEN | busy_q) & RF_OUTPUT_EN;
        end
    end

`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
    // Sticky warm-up violation flag, cleared only by reset.
    always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
        if (!RESET_N)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end
    assign PREGEN_ERR = err_q;
`endif

    assign PA_EN           = pa_en_q;
    assign TX_GATE         = tx_gate_q;
    assign PHASE_BIT       = phase_q;
    assign SIGNAL_GEN_OVER = over_q;
    assign GEN_BUSY        = busy_q;

endmodule

// File: tb/tb_pulse_code_gen.sv
// Directed bench for pulse_code_gen; sample index k counts edges after the
// start edge (k=0 is the first TX cycle), outputs sampled 1 time unit after it.
module tb_pulse_code_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gen, pre_gen, rf_en;
    logic [31:0] code;
    logic [15:0] code_len, code_dur, pulse_len;
    logic        pa_en, tx_gate, phase, over, busy;
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
    logic        pregen_err;
`endif

    int total = 0;
    int bad   = 0;

    pulse_code_gen #(.MAX_CHIPS(32)) dut (
        .CLOCK_10M      (clk),
        .RESET_N        (rst_n),
        .GEN            (gen),
        .PRE_GEN        (pre_gen),
        .CODE           (code),
        .CODE_LEN       (code_len),
        .CODE_DURATION  (code_dur),
        .PULSE_LEN      (pulse_len),
        .RF_OUTPUT_EN   (rf_en),
        .PA_EN          (pa_en),
        .TX_GATE        (tx_gate),
        .PHASE_BIT      (phase),
        .SIGNAL_GEN_OVER(over),
        .GEN_BUSY       (busy)
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
       ,.PREGEN_ERR     (pregen_err)
`endif
    );

    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [31:0] c, input logic [15:0] l,
                         input logic [15:0] d, input logic [15:0] p, input logic rf);
        code = c; code_len = l; code_dur = d; pulse_len = p; rf_en = rf;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; gen = 1'b0; pre_gen = 1'b1;
        setup(32'h0, 16'd0, 16'd0, 16'd0, 1'b1);
        tick(); tick();
        total++;
        if ({pa_en, tx_gate, phase, over, busy} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000", {pa_en, tx_gate, phase, over, busy});
        end
        #20 rst_n = 1'b1;
        tick(); tick();
    endtask

    // REQ-021 frame, with inputs scrambled right after the start edge.
    task automatic test_basic();
        logic [11:0] exp_ph;
        exp_ph = 12'b1111_1100_0111;   // bit k = expected PHASE_BIT at k
        setup(32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1);
        tick();
        gen = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            if (k == 0) setup(32'hFFFF_FFF0, 16'd2, 16'd7, 16'd3, 1'b1);
            total++;
            if (tx_gate !== (k < 12)) begin
                bad++; $display("FAIL basic_tx k=%0d got=%b exp=%b", k, tx_gate, (k < 12));
            end
            total++;
            if (phase !== ((k < 12) ? exp_ph[k] : 1'b0)) begin
                bad++; $display("FAIL basic_phase k=%0d got=%b", k, phase);
            end
            total++;
            if (over !== (k == 20)) begin
                bad++; $display("FAIL basic_over k=%0d got=%b exp=%b", k, over, (k == 20));
            end
            total++;
            if (busy !== 1'b1 || pa_en !== 1'b1) begin
                bad++; $display("FAIL basic_busy_pa k=%0d busy=%b pa=%b exp=1/1", k, busy, pa_en);
            end
        end
        tick();
        total++;
        if (over !== 1'b1) begin
            bad++; $display("FAIL basic_over_hold got=%b exp=1", over);
        end
        gen = 1'b0;
        tick();
        total++;
        if (over !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_over_clear over=%b busy=%b exp=0/0", over, busy);
        end
        tick();
    endtask

    // REQ-022: clamps to one 1-clock chip, then to 32 chips.
    task automatic test_clamp();
        logic [31:0] c;
        setup(32'h0000_0001, 16'd0, 16'd0, 16'd0, 1'b1);
        gen = 1'b1;
        tick();
        total++;
        if ({tx_gate, phase, over} !== 3'b110) begin
            bad++; $display("FAIL clamp_min_k0 got=%b exp=110", {tx_gate, phase, over});
        end
        tick();
        total++;
        if ({tx_gate, phase, over} !== 3'b001) begin
            bad++; $display("FAIL clamp_min_k1 got=%b exp=001", {tx_gate, phase, over});
        end
        gen = 1'b0;
        tick(); tick();
        c = 32'h5555_5555;
        setup(c, 16'd40, 16'd1, 16'd0, 1'b1);
        gen = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            tick();
            total++;
            if (tx_gate !== (k < 32) || phase !== ((k < 32) ? c[k % 32] : 1'b0)) begin
                bad++; $display("FAIL clamp_max k=%0d tx=%b ph=%b exp=%b/%b", k, tx_gate, phase,
                                (k < 32), (k < 32) ? c[k % 32] : 1'b0);
            end
            total++;
            if (over !== (k == 32)) begin
                bad++; $display("FAIL clamp_max_over k=%0d got=%b exp=%b", k, over, (k == 32));
            end
        end
        gen = 1'b0;
        tick(); tick();
    endtask

    // REQ-023: RF disabled, phase still follows the code.
    task automatic test_rf_off();
        logic [31:0] c;
        c = 32'h0000_00A5;
        setup(c, 16'd8, 16'd10, 16'd0, 1'b0);
        gen = 1'b1;
        for (int k = 0; k <= 80; k++) begin
            tick();
            total++;
            if (tx_gate !== 1'b0 || pa_en !== 1'b0) begin
                bad++; $display("FAIL rfoff_gate k=%0d tx=%b pa=%b exp=0/0", k, tx_gate, pa_en);
            end
            total++;
            if (phase !== ((k < 80) ? c[k / 10] : 1'b0)) begin
                bad++; $display("FAIL rfoff_phase k=%0d got=%b", k, phase);
            end
            total++;
            if (over !== (k == 80)) begin
                bad++; $display("FAIL rfoff_over k=%0d got=%b exp=%b", k, over, (k == 80));
            end
        end
        gen = 1'b0;
        tick(); tick();
    endtask

    // REQ-024: abort in TX, then a fresh full frame.
    task automatic test_abort();
        setup(32'h0000_000D, 16'd4, 16'd3, 16'd20, 1'b1);
        gen = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (tx_gate !== 1'b1) begin
            bad++; $display("FAIL abort_pre_tx got=%b exp=1", tx_gate);
        end
        gen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if ({tx_gate, phase, over, busy} !== 4'b0) begin
                bad++; $display("FAIL abort_outputs k=%0d got=%b exp=0000", k, {tx_gate, phase, over, busy});
            end
        end
        gen = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            tick();
            total++;
            if (tx_gate !== (k < 12) || over !== (k == 20)) begin
                bad++; $display("FAIL abort_refire k=%0d tx=%b over=%b exp=%b/%b", k, tx_gate, over,
                                (k < 12), (k == 20));
            end
        end
        gen = 1'b0;
        tick(); tick();
    endtask

    // REQ-025: async reset in TAIL, GEN held high across release.
    task automatic test_reset_mid();
        setup(32'h0000_0003, 16'd2, 16'd2, 16'd20, 1'b1);
        gen = 1'b1;
        for (int k = 0; k <= 6; k++) tick();
        total++;
        if (busy !== 1'b1 || pa_en !== 1'b1 || tx_gate !== 1'b0) begin
            bad++; $display("FAIL rst_tail_state busy=%b pa=%b tx=%b exp=1/1/0", busy, pa_en, tx_gate);
        end
        #20 rst_n = 1'b0;
        #1;
        total++;
        if ({pa_en, tx_gate, phase, over, busy} !== 5'b0) begin
            bad++; $display("FAIL rst_async got=%b exp=00000", {pa_en, tx_gate, phase, over, busy});
        end
        #20 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            total++;
            if (tx_gate !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL rst_no_retrigger k=%0d tx=%b busy=%b exp=0/0", k, tx_gate, busy);
            end
        end
        gen = 1'b0;
        tick();
        gen = 1'b1;
        tick();
        total++;
        if (tx_gate !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL rst_fresh_start tx=%b busy=%b exp=1/1", tx_gate, busy);
        end
        gen = 1'b0;
        tick(); tick();
    endtask

    task automatic test_pregen();
        pre_gen = 1'b0;
        setup(32'h0000_0001, 16'd4, 16'd3, 16'd0, 1'b1);
        gen = 1'b1;
        tick();
`ifdef PULSE_CODE_GEN_PREGEN_CHECK_EN
        total++;
        if ({tx_gate, over, busy, pregen_err} !== 4'b0111) begin
            bad++; $display("FAIL pregen_reject got=%b exp=0111", {tx_gate, over, busy, pregen_err});
        end
        gen = 1'b0;
        tick(); tick();
        total++;
        if (pregen_err !== 1'b1 || over !== 1'b0) begin
            bad++; $display("FAIL pregen_sticky err=%b over=%b exp=1/0", pregen_err, over);
        end
        #20 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        tick();
        total++;
        if (pregen_err !== 1'b0) begin
            bad++; $display("FAIL pregen_clear got=%b exp=0", pregen_err);
        end
`else
        total++;
        if (tx_gate !== 1'b1 || phase !== 1'b1 || over !== 1'b0) begin
            bad++; $display("FAIL pregen_ignored tx=%b ph=%b over=%b exp=1/1/0", tx_gate, phase, over);
        end
        gen = 1'b0;
        tick(); tick();
`endif
        pre_gen = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_rf_off();
        test_abort();
        test_reset_mid();
        test_pregen();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
